// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset CPU: IF/ID/EX/MEM/WB control strobes,
// MEM handshake timeout and sticky illegal-op / bus-error flags.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  ALUOp,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemorIOtoReg,
  output logic        Jal,
  output logic [2:0]  state_o,
  output logic        illegal_op,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ITYPE, C_ILL
  } cls_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d, dec_cls;
  logic [7:0] cnt_q, cnt_d;
  logic       ill_q, ill_d;
  logic       berr_q, berr_d;
  logic       run_q;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^Instruction[25:6];

  always_comb begin
    dec_cls = C_ILL;
    casez (Instruction[31:26])
      6'b000000: dec_cls = (Instruction[5:0] == 6'b001000) ? C_JR : C_RTYPE;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b000101: dec_cls = C_BNE;
      6'b000010: dec_cls = C_J;
      6'b000011: dec_cls = C_JAL;
      6'b001???: dec_cls = C_ITYPE;
      default:   dec_cls = C_ILL;
    endcase
  end

  // run_q holds strobes low for the first cycle out of reset so IF starts clean.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IF;
      cls_q   <= C_ILL;
      cnt_q   <= 8'd0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    ill_d        = ill_q;
    berr_d       = berr_q;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 2'd0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUOp        = 2'd0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemorIOtoReg = 1'b0;
    Jal          = 1'b0;
    if (!run_q) begin
      state_d = S_IF;
    end else begin
      unique case (state_q)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          MemRead = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          cls_d = dec_cls;
          if (dec_cls == C_ILL) begin
            ill_d   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_EX;
          end
        end
        S_EX: begin
          state_d = S_IF;
          unique case (cls_q)
            C_RTYPE: begin ALUOp = 2'd2; state_d = S_WB; end
            C_ITYPE: begin ALUOp = 2'd3; state_d = S_WB; end
            C_LW, C_SW: begin ALUOp = 2'd0; state_d = S_MEM; end
            C_BEQ: begin ALUOp = 2'd1; PCWrite = Zero;  PCSrc = 2'd1; end
            C_BNE: begin ALUOp = 2'd1; PCWrite = !Zero; PCSrc = 2'd1; end
            C_J:   begin PCWrite = 1'b1; PCSrc = 2'd2; end
            C_JR:  begin PCWrite = 1'b1; PCSrc = 2'd3; end
            C_JAL: begin PCWrite = 1'b1; PCSrc = 2'd2; RegWrite = 1'b1; Jal = 1'b1; end
            default: state_d = S_IF;
          endcase
        end
        S_MEM: begin
          MemRead  = (cls_q == C_LW);
          MemWrite = (cls_q == C_SW);
          // A ready arriving on the final timeout cycle still completes the access.
          if (mem_ready) begin
            cnt_d   = 8'd0;
            state_d = (cls_q == C_LW) ? S_WB : S_IF;
          end else if (cnt_q == TO_LAST) begin
            cnt_d   = 8'd0;
            berr_d  = 1'b1;
            state_d = S_IF;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_WB: begin
          RegWrite     = 1'b1;
          RegDst       = (cls_q == C_RTYPE);
          MemorIOtoReg = (cls_q == C_LW);
          state_d      = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  assign state_o    = state_q;
  assign illegal_op = ill_q;
  assign bus_err    = berr_q;

endmodule
